// File: rtl/init_ram.sv
// init_ram: byte-lane-writable single-port RAM that self-initialises to INIT_VALUE
// after reset or clear, with optional output register and out-of-range error strobe.
module init_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH = 1024,
    parameter bit RDW_MODE = 1'b0,
    parameter bit OUT_REG = 1'b0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             en,
    input  logic                             we,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be,
    input  logic [ADDR_WIDTH-1:0]            address,
    input  logic [DATA_WIDTH-1:0]            data_in,
    input  logic                             clear,
    output logic                             ready,
    output logic [DATA_WIDTH-1:0]            data_out,
    output logic                             rd_valid,
    output logic                             err
);
    localparam int LANES = DATA_WIDTH / BYTE_WIDTH;
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    typedef enum logic {INIT, RUN} state_t;

    state_t                state;
    logic [IW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [IW-1:0]         idx;
    logic                  in_range;
    logic                  acc;
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] rdata;

    assign idx = address[IW-1:0];
    assign in_range = {1'b0, address} < (ADDR_WIDTH+1)'(DEPTH);
    assign acc = ready && en && !clear;
    assign old_word = in_range ? mem[idx] : '0;
    assign rdata = !in_range ? '0 : RDW_MODE ? merged : old_word;

    always_comb begin
        merged = old_word;
        for (int i = 0; i < LANES; i++)
            if (be[i]) merged[i*BYTE_WIDTH +: BYTE_WIDTH] = data_in[i*BYTE_WIDTH +: BYTE_WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
            cnt <= '0;
            ready <= 1'b0;
        end else if (state == INIT) begin
            cnt <= cnt + 1'b1;
            if (cnt == IW'(DEPTH - 1)) begin
                state <= RUN;
                ready <= 1'b1;
                cnt <= '0;
            end
        end else if (clear) begin
            state <= INIT;
            ready <= 1'b0;
            cnt <= '0;
        end
    end

    // Contents are never reset; the INIT sweep rewrites every word instead.
    always_ff @(posedge clk) begin
        if (state == INIT) mem[cnt] <= INIT_VALUE;
        else if (acc && we && in_range) mem[idx] <= merged;
    end

    if (OUT_REG) begin : g_reg
        logic                  v1;
        logic                  e1;
        logic [DATA_WIDTH-1:0] d1;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v1 <= 1'b0;
                e1 <= 1'b0;
                d1 <= '0;
                rd_valid <= 1'b0;
                err <= 1'b0;
                data_out <= '0;
            end else begin
                v1 <= acc;
                e1 <= acc && !in_range;
                if (acc) d1 <= rdata;
                rd_valid <= v1;
                err <= e1;
                if (v1) data_out <= d1;
            end
        end
    end else begin : g_dir
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_valid <= 1'b0;
                err <= 1'b0;
                data_out <= '0;
            end else begin
                rd_valid <= acc;
                err <= acc && !in_range;
                if (acc) data_out <= rdata;
            end
        end
    end
endmodule

// File: tb/tb_init_ram.sv
// tb_init_ram: directed checks of init_ram; instance a is read-first with output
// register, instance b is write-first without, both driven by the same stimulus.
module tb_init_ram;
    localparam logic [31:0] IV = 32'h5A5A_0F0F;

    logic        clk, rst_n, en, we, clear;
    logic [3:0]  be;
    logic [4:0]  address;
    logic [31:0] data_in;
    logic        ready_a, ready_b, rv_a, rv_b, err_a, err_b;
    logic [31:0] dout_a, dout_b;
    int tests = 0;
    int fails = 0;

    init_ram #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(5), .DEPTH(16),
               .RDW_MODE(1'b0), .OUT_REG(1'b1), .INIT_VALUE(IV)) a (
        .clk(clk), .rst_n(rst_n), .en(en), .we(we), .be(be), .address(address),
        .data_in(data_in), .clear(clear), .ready(ready_a), .data_out(dout_a),
        .rd_valid(rv_a), .err(err_a));

    init_ram #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(5), .DEPTH(16),
               .RDW_MODE(1'b1), .OUT_REG(1'b0), .INIT_VALUE(IV)) b (
        .clk(clk), .rst_n(rst_n), .en(en), .we(we), .be(be), .address(address),
        .data_in(data_in), .clear(clear), .ready(ready_b), .data_out(dout_b),
        .rd_valid(rv_b), .err(err_b));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic w, input logic [3:0] bm,
                         input logic [4:0] ad, input logic [31:0] d);
        en = e;
        we = w;
        be = bm;
        address = ad;
        data_in = d;
    endtask

    task automatic read_all;
        for (int k = 0; k < 16; k++) begin
            drive(1, 0, 4'h0, 5'(k), 32'h0);
            tick;
            chk("rdall_b_valid", 32'(rv_b), 1);
            chk("rdall_b_data", dout_b, IV);
            if (k > 0) begin
                chk("rdall_a_valid", 32'(rv_a), 1);
                chk("rdall_a_data", dout_a, IV);
            end
        end
        drive(0, 0, 4'h0, 5'd0, 32'h0);
        tick;
        chk("rdall_a_last_valid", 32'(rv_a), 1);
        chk("rdall_a_last_data", dout_a, IV);
        chk("rdall_b_idle", 32'(rv_b), 0);
    endtask

    task automatic wait_init;
        for (int i = 1; i < 16; i++) begin
            tick;
            chk("init_ready_low_a", 32'(ready_a), 0);
            chk("init_ready_low_b", 32'(ready_b), 0);
            chk("init_no_valid_a", 32'(rv_a), 0);
            chk("init_no_valid_b", 32'(rv_b), 0);
        end
        tick;
        chk("init_ready_high_a", 32'(ready_a), 1);
        chk("init_ready_high_b", 32'(ready_b), 1);
    endtask

    initial begin
        clk = 0;
        rst_n = 0;
        clear = 0;
        drive(0, 0, 4'h0, 5'd0, 32'h0);
        #23;
        chk("rst_ready", 32'(ready_a), 0);
        chk("rst_valid", 32'(rv_a), 0);
        chk("rst_err", 32'(err_a), 0);
        chk("rst_dout_a", dout_a, 0);
        chk("rst_dout_b", dout_b, 0);
        tick;
        rst_n = 1;
        wait_init;
        read_all;

        // byte-lane merge and both read-during-write modes
        drive(1, 1, 4'hF, 5'd5, 32'h1122_3344);
        tick;
        chk("w1_b_data", dout_b, 32'h1122_3344);
        chk("w1_a_valid", 32'(rv_a), 0);
        drive(1, 1, 4'h5, 5'd5, 32'hAABB_CCDD);
        tick;
        chk("w2_b_merged", dout_b, 32'h11BB_33DD);
        chk("w1_a_old", dout_a, IV);
        drive(1, 0, 4'h0, 5'd5, 32'h0);
        tick;
        chk("rd5_b", dout_b, 32'h11BB_33DD);
        chk("w2_a_old", dout_a, 32'h1122_3344);
        drive(0, 0, 4'h0, 5'd0, 32'h0);
        tick;
        chk("rd5_a", dout_a, 32'h11BB_33DD);
        chk("idle_b_valid", 32'(rv_b), 0);
        chk("hold_b", dout_b, 32'h11BB_33DD);
        tick;
        chk("idle_a_valid", 32'(rv_a), 0);
        chk("hold_a", dout_a, 32'h11BB_33DD);

        drive(1, 1, 4'hF, 5'd3, 32'h0);
        tick;
        drive(1, 1, 4'hF, 5'd3, 32'hFFFF_FFFF);
        tick;
        chk("rdw1_new", dout_b, 32'hFFFF_FFFF);
        chk("w3_a_old", dout_a, IV);
        drive(1, 1, 4'h0, 5'd3, 32'h1234_5678);
        tick;
        chk("be0_b", dout_b, 32'hFFFF_FFFF);
        chk("rdw0_old", dout_a, 32'h0);
        drive(1, 0, 4'h0, 5'd3, 32'h0);
        tick;
        chk("rd3_b", dout_b, 32'hFFFF_FFFF);
        chk("be0_a_old", dout_a, 32'hFFFF_FFFF);
        drive(0, 0, 4'h0, 5'd0, 32'h0);
        tick;
        chk("rd3_a", dout_a, 32'hFFFF_FFFF);

        // out-of-range accesses
        drive(1, 0, 4'h0, 5'd20, 32'h0);
        tick;
        chk("oor_rd_b_valid", 32'(rv_b), 1);
        chk("oor_rd_b_err", 32'(err_b), 1);
        chk("oor_rd_b_data", dout_b, 0);
        drive(1, 1, 4'hF, 5'd20, 32'hDEAD_BEEF);
        tick;
        chk("oor_wr_b_err", 32'(err_b), 1);
        chk("oor_wr_b_data", dout_b, 0);
        chk("oor_rd_a_valid", 32'(rv_a), 1);
        chk("oor_rd_a_err", 32'(err_a), 1);
        chk("oor_rd_a_data", dout_a, 0);
        drive(1, 0, 4'h0, 5'd4, 32'h0);
        tick;
        chk("alias4_b", dout_b, IV);
        chk("alias4_b_err", 32'(err_b), 0);
        chk("oor_wr_a_err", 32'(err_a), 1);
        drive(0, 0, 4'h0, 5'd0, 32'h0);
        tick;
        chk("alias4_a", dout_a, IV);
        chk("alias4_a_err", 32'(err_a), 0);
        chk("oor_b_idle", 32'(rv_b), 0);

        // clear with a read in flight, simultaneous en, clear ignored during INIT
        drive(1, 0, 4'h0, 5'd5, 32'h0);
        tick;
        chk("pre_clear_b", dout_b, 32'h11BB_33DD);
        drive(1, 1, 4'hF, 5'd7, 32'hCAFE_F00D);
        clear = 1;
        tick;
        chk("clr_ready", 32'(ready_a), 0);
        chk("clr_b_no_valid", 32'(rv_b), 0);
        chk("clr_inflight_a_valid", 32'(rv_a), 1);
        chk("clr_inflight_a_data", dout_a, 32'h11BB_33DD);
        clear = 0;
        drive(1, 1, 4'hF, 5'd5, 32'h0);
        for (int i = 1; i < 16; i++) begin
            clear = (i == 8);
            tick;
            chk("clr_ready_low", 32'(ready_a), 0);
            chk("clr_no_valid_a", 32'(rv_a), 0);
            chk("clr_no_valid_b", 32'(rv_b), 0);
        end
        clear = 0;
        drive(0, 0, 4'h0, 5'd0, 32'h0);
        tick;
        chk("clr_ready_high", 32'(ready_a), 1);
        read_all;

        // asynchronous reset with reads in flight
        drive(1, 0, 4'h0, 5'd1, 32'h0);
        tick;
        drive(1, 0, 4'h0, 5'd2, 32'h0);
        tick;
        rst_n = 0;
        drive(0, 0, 4'h0, 5'd0, 32'h0);
        #2;
        chk("arst_a_valid", 32'(rv_a), 0);
        chk("arst_a_data", dout_a, 0);
        chk("arst_b_data", dout_b, 0);
        chk("arst_ready", 32'(ready_a), 0);
        tick;
        rst_n = 1;
        wait_init;
        chk("arst_a_data_after", dout_a, 0);
        read_all;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
